snake_grid_mem: RTL and testbench
=================================

Name: snake_grid_mem

Overview:
Parametrised single-clock true-dual-port grid memory for the snake game board; successor to the fixed 8-bit × 760-word board RAM.
- Two Avalon-MM slave ports: s1 for Nios software, s2 for the LT24 render/game-logic side.
- Adds: configurable width/depth, read latency with readdatavalid, defined write-collision and read-during-write behaviour, range checking, and a hardware board-clear engine that fills the whole memory with a value.

Parameters:
DATA_W, 8, word width in bits (1..32)
DEPTH, 760, number of words
ADDR_W, 10, address width; must satisfy 2**ADDR_W >= DEPTH
RD_LATENCY, 1, cycles from accepted read to readdatavalid (1 or 2)
INIT_FILE, "snake_mem.hex", power-up contents; reset does not reload

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  port s1 word address
chipselect  in  1  port s1 select
read  in  1  port s1 read strobe
write  in  1  port s1 write strobe
writedata  in  DATA_W  port s1 write data
readdata  out  DATA_W  port s1 read data
readdatavalid  out  1  port s1 read data valid
waitrequest  out  1  port s1 stall
address2, chipselect2, read2, write2, writedata2, readdata2, readdatavalid2, waitrequest2: port s2, same directions, widths and meanings as s1
clear_req  in  1  one-cycle pulse that starts a fill
clear_value  in  DATA_W  fill value, captured when clear_req is accepted
clear_busy  out  1  high while a fill is running
clear_done  out  1  one-cycle pulse when a fill completes

Behaviour:
- Reset values: readdata/readdata2 = 0, readdatavalid/readdatavalid2 = 0, waitrequest/waitrequest2 = 0, clear_busy = 0, clear_done = 0. FSM returns to IDLE and the fill counter to 0. Memory contents are not altered by reset.
- Accepted access: chipselect & (read|write) & ~waitrequest. Per port, read and write asserted together is treated as a write; no read response is issued.
- Read latency: data for a read accepted in cycle N appears on readdata with readdatavalid high in cycle N+RD_LATENCY, for exactly one cycle per read.
  - Back-to-back reads are pipelined, one per cycle.
  - readdata holds its last value when readdatavalid is low.
- Write: an accepted write in cycle N updates memory at the clk edge ending cycle N.
- Same-port read-after-write: a read in cycle N+1 returns the data written in cycle N.
- Mixed-port read-during-write, same address, same cycle: the read returns the NEW data (write-first forwarding).
- Dual write, same address, same cycle: s1 wins and the s2 write is dropped.
- Out of range (address >= DEPTH): writes are ignored; reads complete normally with data 0 and readdatavalid still asserted.
- FSM states: IDLE, FILL, DONE.
  - IDLE → FILL on clear_req. Captures clear_value, counter = 0, clear_busy = 1.
  - FILL: writes clear_value to address counter each cycle, counter += 1. Both waitrequest outputs = 1. Reads already in flight still return their data at the normal latency. When counter == DEPTH-1 is written → DONE.
  - DONE: one cycle. clear_done = 1, clear_busy = 0, waitrequest deasserts. → IDLE.
  - A fill takes exactly DEPTH cycles in FILL, plus 1 cycle in DONE.
- clear_req in FILL or DONE: ignored (not queued).
- clear_req in the same cycle as a port write: the write is accepted (waitrequest was low); the fill starts next cycle and will overwrite that location.
- Reset during FILL: fill aborts and memory is left partially filled. No clear_done pulse; clear_busy = 0 on the next cycle.
- Counter width is ADDR_W. DEPTH = 2**ADDR_W must not wrap early; compare on DEPTH-1, not on overflow.

Decomposition:
- Shared package snake_mem_pkg:
  - fill FSM state enum (IDLE/FILL/DONE)
  - default DATA_W/DEPTH/ADDR_W constants
  - function clog2 for ADDR_W checks
- One natural sub-module, snake_mem_rd_pipe: per-port read-valid/data delay line of RTL length RD_LATENCY. Instantiated twice (s1 and s2).
- Storage array, forwarding and the fill FSM stay in the top.

Test Plan:
- Write s1 addr 5 = 0xA3, then read s1 addr 5 at RD_LATENCY=1 → readdatavalid high 1 cycle later with readdata 0xA3. At RD_LATENCY=2 → valid 2 cycles later.
- Same cycle: s1 writes addr 12 = 0x55, s2 reads addr 12 → readdata2 = 0x55. Same cycle: s1 writes 0x11 and s2 writes 0x22 to addr 30 → later read returns 0x11.
- Read addr 800 (DEPTH=760) → readdatavalid with readdata 0. Write addr 759 = 0x7F, then read → 0x7F.
- clear_req with clear_value = 0x00 after random writes:
  - clear_busy high for 760 cycles, then clear_done pulses once.
  - waitrequest/waitrequest2 high throughout.
  - Reads of addresses 0, 379 and 759 all return 0x00.
- Assert reset 100 cycles into a fill → clear_busy = 0 next cycle, no clear_done. Addr 50 = fill value, addr 700 = pre-fill contents.
- 8 back-to-back s2 reads of addrs 0..7 → 8 consecutive readdatavalid2 cycles, data in order.

Source files
------------

// File: rtl/snake_mem_pkg.sv
// Shared types and defaults for the snake board grid memory.
package snake_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 760;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/snake_mem_rd_pipe.sv
// Read-response delay line: carries valid and data STAGES cycles; output data
// only changes when a response arrives, so it holds between reads.
module snake_mem_rd_pipe
  import snake_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // stage p0: capture of the accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= vld_in;
      if (vld_in) data_p0 <= data_in;
    end
  end

  if (STAGES >= 2) begin : g_two_stage
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    // stage p1: second cycle of latency
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end

    assign vld_out  = vld_p1;
    assign data_out = data_p1;
  end else begin : g_one_stage
    assign vld_out  = vld_p0;
    assign data_out = data_p0;
  end

endmodule

// File: rtl/snake_grid_mem.sv
// True-dual-port snake board memory with write-first cross-port forwarding,
// s1-priority write collisions, range checking and a hardware fill engine.
module snake_grid_mem
  import snake_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LATENCY = 1,
  parameter     INIT_FILE  = "snake_mem.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  input  logic [ADDR_W-1:0] address2,
  input  logic              chipselect2,
  input  logic              read2,
  input  logic              write2,
  input  logic [DATA_W-1:0] writedata2,
  output logic [DATA_W-1:0] readdata2,
  output logic              readdatavalid2,
  output logic              waitrequest2,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic              clear_done
);

  if (ADDR_W < clog2(DEPTH)) begin : g_bad_addr_w
    $error("snake_grid_mem: ADDR_W too narrow for DEPTH");
  end

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Power-up image is attached by the FPGA memory-initialisation flow.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              fill_we;

  logic              stall;
  logic              in_range1, in_range2, same_addr;
  logic              rd_acc1, rd_acc2, wr_acc1, wr_acc2;
  logic              wr_en1, wr_en2;
  logic [DATA_W-1:0] rd_data1, rd_data2;

  assign stall          = (state_q == ST_FILL);
  assign waitrequest    = stall;
  assign waitrequest2   = stall;
  assign clear_busy     = stall;
  assign clear_done     = (state_q == ST_DONE);

  // Port decode; a read reports the word as it will be after this cycle's
  // writes from the other port (write-first).
  always_comb begin
    in_range1 = ({1'b0, address}  < DEPTH_EXT);
    in_range2 = ({1'b0, address2} < DEPTH_EXT);
    same_addr = (address == address2);
    wr_acc1   = chipselect  & write  & ~stall;
    wr_acc2   = chipselect2 & write2 & ~stall;
    rd_acc1   = chipselect  & read   & ~write  & ~stall;
    rd_acc2   = chipselect2 & read2  & ~write2 & ~stall;
    wr_en1    = wr_acc1 & in_range1;
    wr_en2    = wr_acc2 & in_range2 & ~(wr_en1 & same_addr);

    rd_data1 = '0;
    if (in_range1) begin
      if (wr_en2 && same_addr) rd_data1 = writedata2;
      else                     rd_data1 = mem[address];
    end

    rd_data2 = '0;
    if (in_range2) begin
      if (wr_en1 && same_addr) rd_data2 = writedata;
      else                     rd_data2 = mem[address2];
    end
  end

  // s1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (fill_we) mem[cnt_q]    <= fill_val_q;
    if (wr_en2)  mem[address2] <= writedata2;
    if (wr_en1)  mem[address]  <= writedata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    fill_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_FILL;
          cnt_d      = '0;
          fill_val_d = clear_value;
        end
      end
      ST_FILL: begin
        fill_we = 1'b1;
        // Compare against the last address so a power-of-two DEPTH never
        // relies on counter wrap.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    fill_val_q <= fill_val_d;
  end

  snake_mem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LATENCY)
  ) u_rd_pipe1 (
    .clk      (clk),
    .rst      (reset),
    .vld_in   (rd_acc1),
    .data_in  (rd_data1),
    .vld_out  (readdatavalid),
    .data_out (readdata)
  );

  snake_mem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LATENCY)
  ) u_rd_pipe2 (
    .clk      (clk),
    .rst      (reset),
    .vld_in   (rd_acc2),
    .data_in  (rd_data2),
    .vld_out  (readdatavalid2),
    .data_out (readdata2)
  );

endmodule

// File: tb/tb_snake_grid_mem.sv
// Directed bench for snake_grid_mem: a latency-1 instance and a latency-2
// instance share the same stimulus.
module tb_snake_grid_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] address, address2;
  logic       chipselect, read, write, chipselect2, read2, write2;
  logic [7:0] writedata, writedata2;
  logic       clear_req;
  logic [7:0] clear_value;

  logic [7:0] readdata, readdata2;
  logic       readdatavalid, readdatavalid2, waitrequest, waitrequest2;
  logic       clear_busy, clear_done;

  logic [7:0] l2_readdata, l2_readdata2;
  logic       l2_readdatavalid, l2_readdatavalid2, l2_waitrequest, l2_waitrequest2;
  logic       l2_clear_busy, l2_clear_done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  snake_grid_mem #(.DATA_W(8), .DEPTH(760), .ADDR_W(10), .RD_LATENCY(1), .INIT_FILE("")) u_dut (
    .clk(clk), .reset(reset),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest),
    .address2(address2), .chipselect2(chipselect2), .read2(read2), .write2(write2),
    .writedata2(writedata2), .readdata2(readdata2), .readdatavalid2(readdatavalid2),
    .waitrequest2(waitrequest2),
    .clear_req(clear_req), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  snake_grid_mem #(.DATA_W(8), .DEPTH(760), .ADDR_W(10), .RD_LATENCY(2), .INIT_FILE("")) u_dut_l2 (
    .clk(clk), .reset(reset),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(l2_readdata), .readdatavalid(l2_readdatavalid),
    .waitrequest(l2_waitrequest),
    .address2(address2), .chipselect2(chipselect2), .read2(read2), .write2(write2),
    .writedata2(writedata2), .readdata2(l2_readdata2), .readdatavalid2(l2_readdatavalid2),
    .waitrequest2(l2_waitrequest2),
    .clear_req(clear_req), .clear_value(clear_value),
    .clear_busy(l2_clear_busy), .clear_done(l2_clear_done)
  );

  typedef struct {
    logic       cs1, rd1, wr1;
    logic [9:0] a1;
    logic [7:0] wd1;
    logic       cs2, rd2, wr2;
    logic [9:0] a2;
    logic [7:0] wd2;
    logic       ev1;
    logic [7:0] ed1;
    logic       ev2;
    logic [7:0] ed2;
  } vec_t;

  function automatic vec_t mk(input int cs1, rd1, wr1, a1, wd1,
                              input int cs2, rd2, wr2, a2, wd2,
                              input int ev1, ed1, ev2, ed2);
    vec_t v;
    v.cs1 = cs1[0]; v.rd1 = rd1[0]; v.wr1 = wr1[0]; v.a1 = a1[9:0]; v.wd1 = wd1[7:0];
    v.cs2 = cs2[0]; v.rd2 = rd2[0]; v.wr2 = wr2[0]; v.a2 = a2[9:0]; v.wd2 = wd2[7:0];
    v.ev1 = ev1[0]; v.ed1 = ed1[7:0]; v.ev2 = ev2[0]; v.ed2 = ed2[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0; address2 = '0; writedata2 = '0;
  endtask

  task automatic wr_s1(input int a, input int d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a[9:0]; writedata = d[7:0];
    tick();
    idle_ports();
  endtask

  task automatic rd_chk(input int port, input int a, input int exp, input string nm);
    if (port == 1) begin
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a[9:0];
    end else begin
      chipselect2 = 1'b1; read2 = 1'b1; write2 = 1'b0; address2 = a[9:0];
    end
    tick();
    idle_ports();
    if (port == 1) begin
      chk({nm, "_vld"}, readdatavalid, 1);
      chk(nm, readdata, exp);
    end else begin
      chk({nm, "_vld"}, readdatavalid2, 1);
      chk(nm, readdata2, exp);
    end
  endtask

  vec_t vecs [14];

  initial begin
    int busy_cnt, wr_bad, cyc, l2_cnt, late_done;
    bit seen_done;
    logic done_busy, done_wr;

    reset = 1'b1; clear_req = 1'b0; clear_value = '0;
    idle_ports();

    vecs[0]  = mk(1,0,1,  5,'hA3, 0,0,0,  0,'h00, 0,'h00, 0,'h00);
    vecs[1]  = mk(1,1,0,  5,'h00, 0,0,0,  0,'h00, 1,'hA3, 0,'h00);
    vecs[2]  = mk(1,0,1, 12,'h55, 1,1,0, 12,'h00, 0,'hA3, 1,'h55);
    vecs[3]  = mk(1,0,1, 30,'h11, 1,0,1, 30,'h22, 0,'hA3, 0,'h55);
    vecs[4]  = mk(1,1,0, 30,'h00, 1,1,0, 30,'h00, 1,'h11, 1,'h11);
    vecs[5]  = mk(1,1,0,800,'h00, 0,0,0,  0,'h00, 1,'h00, 0,'h11);
    vecs[6]  = mk(1,0,1,759,'h7F, 1,0,1,800,'hEE, 0,'h00, 0,'h11);
    vecs[7]  = mk(1,1,0,800,'h00, 1,1,0,759,'h00, 1,'h00, 1,'h7F);
    vecs[8]  = mk(1,1,1, 40,'h5A, 0,0,0,  0,'h00, 0,'h00, 0,'h7F);
    vecs[9]  = mk(0,0,0,  0,'h00, 1,1,0, 40,'h00, 0,'h00, 1,'h5A);
    vecs[10] = mk(1,1,0, 12,'h00, 1,0,1, 12,'h66, 1,'h66, 0,'h5A);
    vecs[11] = mk(0,1,0,  5,'h00, 0,1,0,  5,'h00, 0,'h66, 0,'h5A);
    vecs[12] = mk(1,1,0,  5,'h00, 1,1,0, 12,'h00, 1,'hA3, 1,'h66);
    vecs[13] = mk(0,0,0,  0,'h00, 0,0,0,  0,'h00, 0,'hA3, 0,'h66);

    tick(); tick();
    chk("rst_readdata",   readdata, 0);
    chk("rst_readdata2",  readdata2, 0);
    chk("rst_rdvalid",    readdatavalid, 0);
    chk("rst_rdvalid2",   readdatavalid2, 0);
    chk("rst_waitreq",    waitrequest, 0);
    chk("rst_waitreq2",   waitrequest2, 0);
    chk("rst_busy",       clear_busy, 0);
    chk("rst_done",       clear_done, 0);
    reset = 1'b0;
    tick();

    // Single-cycle transactions; response of vector i is checked one cycle
    // later on the latency-1 instance and two cycles later on latency-2.
    for (int i = 0; i < 14; i++) begin
      chipselect = vecs[i].cs1; read = vecs[i].rd1; write = vecs[i].wr1;
      address = vecs[i].a1; writedata = vecs[i].wd1;
      chipselect2 = vecs[i].cs2; read2 = vecs[i].rd2; write2 = vecs[i].wr2;
      address2 = vecs[i].a2; writedata2 = vecs[i].wd2;
      tick();
      chk($sformatf("vec%0d_vld1", i), readdatavalid,  vecs[i].ev1);
      chk($sformatf("vec%0d_rd1",  i), readdata,       vecs[i].ed1);
      chk($sformatf("vec%0d_vld2", i), readdatavalid2, vecs[i].ev2);
      chk($sformatf("vec%0d_rd2",  i), readdata2,      vecs[i].ed2);
      if (i >= 1) begin
        chk($sformatf("lat2_vec%0d_vld1", i - 1), l2_readdatavalid,  vecs[i-1].ev1);
        chk($sformatf("lat2_vec%0d_rd1",  i - 1), l2_readdata,       vecs[i-1].ed1);
        chk($sformatf("lat2_vec%0d_vld2", i - 1), l2_readdatavalid2, vecs[i-1].ev2);
        chk($sformatf("lat2_vec%0d_rd2",  i - 1), l2_readdata2,      vecs[i-1].ed2);
      end
    end
    idle_ports();

    // Eight back-to-back s2 reads.
    for (int i = 0; i < 8; i++) wr_s1(i, 'h10 + i);
    l2_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chipselect2 = 1'b1; read2 = 1'b1; address2 = 10'(i);
      tick();
      if (l2_readdatavalid2) l2_cnt++;
      chk($sformatf("burst%0d_vld2", i), readdatavalid2, 1);
      chk($sformatf("burst%0d_rd2", i),  readdata2, 'h10 + i);
    end
    idle_ports();
    tick();
    if (l2_readdatavalid2) l2_cnt++;
    chk("burst_end_vld2", readdatavalid2, 0);
    chk("burst_end_hold2", readdata2, 'h17);
    tick();
    if (l2_readdatavalid2) l2_cnt++;
    chk("lat2_burst_count", l2_cnt, 8);
    chk("lat2_burst_last", l2_readdata2, 'h17);

    // Fill with 0x00 after arbitrary writes; a port write in the clear_req cycle.
    wr_s1(379, $urandom_range(1, 255));
    wr_s1(759, $urandom_range(1, 255));
    wr_s1(100, $urandom_range(1, 255));
    clear_req = 1'b1; clear_value = 8'h00;
    chipselect = 1'b1; write = 1'b1; address = 10'd0; writedata = 8'hBB;
    tick();
    clear_req = 1'b0;
    idle_ports();
    busy_cnt = 0; wr_bad = 0; cyc = 0; seen_done = 0; done_busy = 1'b1; done_wr = 1'b1;
    while (!seen_done && cyc < 2000) begin
      if (clear_done) begin
        seen_done = 1;
        done_busy = clear_busy;
        done_wr = waitrequest | waitrequest2;
      end else begin
        if (clear_busy) busy_cnt++;
        if (waitrequest !== clear_busy || waitrequest2 !== clear_busy) wr_bad++;
      end
      clear_req = (busy_cnt == 10);
      clear_value = 8'h99;
      chipselect = (busy_cnt == 700); write = (busy_cnt == 700);
      address = 10'd5; writedata = 8'h55;
      if (!seen_done) begin
        tick();
        cyc++;
      end
    end
    clear_req = 1'b0; clear_value = 8'h00;
    idle_ports();
    chk("fill_done_seen", seen_done, 1);
    chk("fill_busy_cycles", busy_cnt, 760);
    chk("fill_waitreq_track", wr_bad, 0);
    chk("fill_done_busy_low", done_busy, 0);
    chk("fill_done_waitreq_low", done_wr, 0);
    tick();
    chk("fill_done_single", clear_done, 0);
    chk("fill_req_not_queued", clear_busy, 0);
    rd_chk(1, 0,   0, "fill_addr0");
    rd_chk(1, 379, 0, "fill_addr379");
    rd_chk(2, 759, 0, "fill_addr759");
    rd_chk(1, 5,   0, "fill_stalled_write");

    // Reset 100 cycles into a fill.
    wr_s1(700, 'hC7);
    wr_s1(50, 'h12);
    rd_chk(1, 700, 'hC7, "prefill_addr700");
    rd_chk(2, 50,  'h12, "prefill_addr50");
    clear_req = 1'b1; clear_value = 8'hE5;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("abort_busy_before", clear_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", clear_busy, 0);
    chk("abort_done", clear_done, 0);
    chk("abort_waitreq", waitrequest, 0);
    chk("abort_readdata", readdata, 0);
    chk("abort_readdata2", readdata2, 0);
    late_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (clear_done || clear_busy) late_done++;
    end
    chk("abort_no_done", late_done, 0);
    rd_chk(1, 50,  'hE5, "abort_addr50");
    rd_chk(2, 99,  'hE5, "abort_addr99");
    rd_chk(1, 700, 'hC7, "abort_addr700");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
